// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;
   localparam int unsigned XLEN       = 32;
   localparam logic [31:0] INSTR_HALT = 32'h0000_0000;

   typedef enum logic [1:0] {FS_BOOT, FS_RUN, FS_HALT} fetch_state_t;
endpackage

// File: rtl/fetch_pc_mux.sv
// Instruction memory address select and redirect-target legality check.
module fetch_pc_mux
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN      = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int unsigned     MEM_WORDS = 32
) (
   input  logic            boot,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            stall,
   input  logic            if_valid,
   input  logic [XLEN-1:0] inflight_pc,
   input  logic [XLEN-1:0] pc_q,
   output logic [XLEN-1:0] imem_pc,
   output logic            target_ok
);
   localparam logic [XLEN-1:0] MEM_LIMIT = XLEN'(MEM_WORDS * 4);

   always_comb begin
      imem_pc = pc_q;
      if (boot)
         imem_pc = RESET_PC;
      else if (branch_taken)
         imem_pc = {branch_target[XLEN-1:2], 2'b00};
      else if (stall && if_valid)
         imem_pc = inflight_pc;
   end

   assign target_ok = (branch_target[1:0] == 2'b00) && (branch_target < MEM_LIMIT);
endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, tracks the 1-cycle memory latency and presents
// (if_pc, if_instr, if_valid) to decode with stall, redirect and halt handling.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN      = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int unsigned     MEM_WORDS = 32
) (
   input  logic            clock,
   input  logic            reset,
   output logic [XLEN-1:0] imem_pc,
   input  logic [31:0]     imem_instr,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instr,
   output logic            if_valid,
   output logic            halted,
   output logic            fault,
   output logic [31:0]     fetch_count
);
   localparam logic [XLEN-1:0] MEM_LIMIT = XLEN'(MEM_WORDS * 4);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inflight_pc, inflight_pc_d;
   logic            inflight_valid, inflight_valid_d;
   logic            fault_q, fault_d;
   logic [31:0]     count_q, count_d;
   logic            target_ok;
   logic            accept;

   fetch_pc_mux #(
      .XLEN      (XLEN),
      .RESET_PC  (RESET_PC),
      .MEM_WORDS (MEM_WORDS)
   ) u_pc_mux (
      .boot          (state_q == FS_BOOT),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .stall         (stall),
      .if_valid      (if_valid),
      .inflight_pc   (inflight_pc),
      .pc_q          (pc_q),
      .imem_pc       (imem_pc),
      .target_ok     (target_ok)
   );

   assign if_pc       = inflight_pc;
   assign if_instr    = imem_instr;
   assign if_valid    = inflight_valid && (state_q != FS_HALT);
   assign halted      = (state_q == FS_HALT);
   assign fault       = fault_q;
   assign fetch_count = count_q;

   // The terminating zero word is consumed by the halt, never handed to decode.
   assign accept = if_valid && !stall && !branch_taken && (imem_instr != INSTR_HALT);

   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      inflight_pc_d    = inflight_pc;
      inflight_valid_d = inflight_valid;
      fault_d          = fault_q;
      count_d          = count_q + 32'(accept);
      case (state_q)
         FS_BOOT: begin
            inflight_pc_d    = RESET_PC;
            inflight_valid_d = 1'b1;
            pc_d             = RESET_PC + XLEN'(4);
            state_d          = FS_RUN;
         end
         FS_RUN: begin
            if (branch_taken) begin
               if (!target_ok) begin
                  state_d = FS_HALT;
                  fault_d = 1'b1;
               end else begin
                  inflight_pc_d    = branch_target;
                  inflight_valid_d = 1'b1;
                  pc_d             = branch_target + XLEN'(4);
               end
            end else if (stall && if_valid) begin
               state_d = FS_RUN;
            end else if (if_valid && (imem_instr == INSTR_HALT)) begin
               state_d = FS_HALT;
            end else if (pc_q >= MEM_LIMIT) begin
               state_d = FS_HALT;
               fault_d = 1'b1;
            end else begin
               inflight_pc_d    = pc_q;
               inflight_valid_d = 1'b1;
               pc_d             = pc_q + XLEN'(4);
            end
         end
         FS_HALT: state_d = FS_HALT;
         default: state_d = FS_HALT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= FS_BOOT;
         pc_q           <= RESET_PC;
         inflight_pc    <= '0;
         inflight_valid <= 1'b0;
         fault_q        <= 1'b0;
         count_q        <= '0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         inflight_pc    <= inflight_pc_d;
         inflight_valid <= inflight_valid_d;
         fault_q        <= fault_d;
         count_q        <= count_d;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a registered-read instruction memory model,
// directed vector tables and a randomized run against a PC-level reference model.
module tb_fetch_unit;
   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;
   logic        halted;
   logic        fault;
   logic [31:0] fetch_count;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [31:0] rom [32];

   fetch_unit #(
      .XLEN      (32),
      .RESET_PC  (32'h0),
      .MEM_WORDS (32)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .imem_pc       (imem_pc),
      .imem_instr    (imem_instr),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .if_pc         (if_pc),
      .if_instr      (if_instr),
      .if_valid      (if_valid),
      .halted        (halted),
      .fault         (fault),
      .fetch_count   (fetch_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock)
      imem_instr <= (imem_pc < 32'd128) ? rom[imem_pc[6:2]] : 32'h0;

   typedef struct {
      logic        rst, st, br;
      logic [31:0] tgt;
      logic        chk, v;
      logic [31:0] pc;
      logic        h, f;
      logic [31:0] cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, st, br, input logic [31:0] tgt, input logic chk, v,
                      input logic [31:0] pc, input logic h, f, input logic [31:0] cnt);
      vec_t e;
      e.rst = rst; e.st = st; e.br = br; e.tgt = tgt; e.chk = chk; e.v = v;
      e.pc = pc; e.h = h; e.f = f; e.cnt = cnt;
      tbl.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state: address of the instruction on show, plus flags.
   logic        m_known, m_boot, m_valid, m_halted, m_fault;
   logic [31:0] m_cur, m_count;

   task automatic model_step(input logic rst, st, br, input logic [31:0] tgt);
      logic [31:0] w;
      w = rom[m_cur[6:2]];
      if (rst) begin
         m_known = 1; m_boot = 1; m_valid = 0; m_halted = 0; m_fault = 0;
         m_cur = 0; m_count = 0;
      end else if (!m_known || m_halted) begin
      end else if (m_boot) begin
         m_boot = 0; m_valid = 1; m_cur = 0;
      end else begin
         if (!br && !st && w != 0) m_count = m_count + 1;
         if (br) begin
            if (tgt % 4 != 0 || tgt >= 128) begin m_halted = 1; m_fault = 1; end
            else m_cur = tgt;
         end else if (st) begin
         end else if (w == 0) begin
            m_halted = 1;
         end else if (m_cur + 4 >= 128) begin
            m_halted = 1; m_fault = 1;
         end else begin
            m_cur = m_cur + 4;
         end
      end
   endtask

   initial begin
      for (int unsigned i = 0; i < 32; i++) rom[i] = 32'h0000_0013;
      rom[0]  = 32'h0010_0133; rom[1]  = 32'h000A_2183; rom[2]  = 32'h0031_0233;
      rom[3]  = 32'h0041_8293; rom[4]  = 32'h0052_0333; rom[5]  = 32'h0062_8393;
      rom[6]  = 32'h0020_8663; rom[7]  = 32'h0073_0433; rom[8]  = 32'h0083_84B3;
      rom[9]  = 32'h0094_0533; rom[10] = 32'h00A8_2023; rom[11] = 32'h0000_0000;

      // Free run, with a 3-cycle stall at 0x08, to the zero word at 0x2C.
      add(1,0,0,0, 0,0,0,0,0,0);
      add(1,0,0,0, 1,0,0,0,0,0);
      add(0,0,0,0, 1,0,0,0,0,0);
      add(0,0,0,0, 1,1,32'h00,0,0,0);
      add(0,0,0,0, 1,1,32'h04,0,0,1);
      add(0,1,0,0, 1,1,32'h08,0,0,2);
      add(0,1,0,0, 1,1,32'h08,0,0,2);
      add(0,1,0,0, 1,1,32'h08,0,0,2);
      add(0,0,0,0, 1,1,32'h08,0,0,2);
      for (int unsigned k = 3; k <= 11; k++) add(0,0,0,0, 1,1,32'(4*k),0,0,32'(k));
      add(0,0,0,0,     1,0,0,1,0,11);
      add(0,0,1,0,     1,0,0,1,0,11);
      // Redirect at 0x04, redirect+stall at 0x1C, misaligned target fault.
      add(1,0,0,0, 0,0,0,0,0,0);
      add(1,0,0,0, 1,0,0,0,0,0);
      add(0,0,0,0, 1,0,0,0,0,0);
      add(0,0,0,0,      1,1,32'h00,0,0,0);
      add(0,0,1,32'h18, 1,1,32'h04,0,0,1);
      add(0,0,0,0,      1,1,32'h18,0,0,1);
      add(0,1,1,32'h00, 1,1,32'h1C,0,0,2);
      add(0,0,0,0,      1,1,32'h00,0,0,2);
      add(0,0,1,32'h06, 1,1,32'h04,0,0,3);
      add(0,0,1,32'h00, 1,0,0,1,1,3);
      add(0,1,0,0,      1,0,0,1,1,3);
      // Out-of-range target fault.
      add(1,0,0,0, 0,0,0,0,0,0);
      add(1,0,0,0, 1,0,0,0,0,0);
      add(0,0,0,0, 1,0,0,0,0,0);
      add(0,0,1,32'h80, 1,1,32'h00,0,0,0);
      add(0,0,1,32'h10, 1,0,0,1,1,0);
      add(0,0,0,0,      1,0,0,1,1,0);
      // Reset asserted during a stall at 0x10.
      add(1,0,0,0, 0,0,0,0,0,0);
      add(1,0,0,0, 1,0,0,0,0,0);
      add(0,0,0,0, 1,0,0,0,0,0);
      for (int unsigned k = 0; k < 4; k++) add(0,0,0,0, 1,1,32'(4*k),0,0,32'(k));
      add(0,1,0,0, 1,1,32'h10,0,0,4);
      add(0,1,0,0, 1,1,32'h10,0,0,4);
      add(1,1,0,0, 1,1,32'h10,0,0,4);
      add(0,1,0,0, 1,0,0,0,0,0);
      add(0,0,0,0, 1,1,32'h00,0,0,0);
      add(0,0,0,0, 1,1,32'h04,0,0,1);

      reset = 1; stall = 0; branch_taken = 0; branch_target = 0;
      #1;
      foreach (tbl[i]) begin
         reset = tbl[i].rst; stall = tbl[i].st;
         branch_taken = tbl[i].br; branch_target = tbl[i].tgt;
         @(negedge clock);
         if (tbl[i].chk) begin
            check($sformatf("vec%0d if_valid", i), 32'(if_valid), 32'(tbl[i].v));
            check($sformatf("vec%0d halted", i),   32'(halted),   32'(tbl[i].h));
            check($sformatf("vec%0d fault", i),    32'(fault),    32'(tbl[i].f));
            check($sformatf("vec%0d count", i),    fetch_count,   tbl[i].cnt);
            if (tbl[i].v) begin
               check($sformatf("vec%0d if_pc", i),    if_pc,    tbl[i].pc);
               check($sformatf("vec%0d if_instr", i), if_instr, rom[tbl[i].pc[6:2]]);
            end
         end
         @(posedge clock); #1;
      end

      m_known = 0; m_boot = 0; m_valid = 0; m_halted = 0; m_fault = 0;
      m_cur = 0; m_count = 0;
      for (int unsigned c = 0; c < 3000; c++) begin
         logic        rst, st, br, ev;
         logic [31:0] tgt, epc;
         rst = (c == 0) || (m_halted && $urandom_range(3) == 0) || ($urandom_range(63) == 0);
         st  = ($urandom_range(2) == 0);
         br  = ($urandom_range(4) == 0);
         tgt = ($urandom_range(9) == 0) ? 32'($urandom_range(255)) : 32'($urandom_range(31) * 4);
         reset = rst; stall = st; branch_taken = br; branch_target = tgt;
         ev  = m_valid && !m_halted;
         if (m_boot)         epc = 32'h0;
         else if (br)        epc = tgt & ~32'h3;
         else if (st && ev)  epc = m_cur;
         else                epc = m_cur + 4;
         @(negedge clock);
         if (m_known) begin
            check("rand if_valid", 32'(if_valid), 32'(ev));
            check("rand halted",   32'(halted),   32'(m_halted));
            check("rand fault",    32'(fault),    32'(m_fault));
            check("rand count",    fetch_count,   m_count);
            if (ev) begin
               check("rand if_pc",    if_pc,    m_cur);
               check("rand if_instr", if_instr, rom[m_cur[6:2]]);
            end
            if (!m_halted) check("rand imem_pc", imem_pc, epc);
         end
         model_step(rst, st, br, tgt);
         @(posedge clock); #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
